// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge
//  Data-side bridge between the core LSU and N_REGIONS memory-mapped slaves.
//  The bridge decodes the LSU address to a region and runs a valid/ready
//  handshake with that slave on a shared request bus. The core is stalled
//  until the access completes. Unmapped addresses raise an access fault.
//
//  Optional feature: define COTM32_BUS_TIMEOUT_EN to fault an access after
//  TIMEOUT_CYCLES ACCESS cycles without ready. When it is undefined, ACCESS
//  waits indefinitely.
//
//  Ports
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_req/i_we/i_addr/       LSU request; the core holds it stable until done/fault
//   i_wdata/i_wstrb
//   i_trap_req               blocks acceptance of a new request
//   o_stall                  freeze the core while the access is outstanding
//   o_done, o_rdata          completion pulse; load data is held until the next load completes
//   o_t_access_fault,        fault pulse; o_fault_store is 1 for a store
//   o_fault_store
//   o_m_valid                per-slave valid (one-hot or zero)
//   o_m_we/addr/wdata/wstrb  shared slave request bus
//   i_m_ready, i_m_rdata     per-slave ready and read data
//
//  state  | meaning
//  IDLE   | waiting for a request; decode and latch it on acceptance
//  ACCESS | valid asserted to the selected slave, waiting for ready
//  RESP   | one-cycle o_done pulse
//  FAULT  | one-cycle access-fault pulse; no slave is touched
module lsu_bus_bridge #(
   parameter int XLEN           = 32,
   parameter int N_REGIONS      = 2,
   parameter logic [N_REGIONS-1:0][XLEN-1:0] REGION_BASE = {32'h1000_0000, 32'h0},
   parameter logic [N_REGIONS-1:0][XLEN-1:0] REGION_MASK = {32'hF000_0000, 32'hF000_0000},
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_req,
   input  logic                      i_we,
   input  logic [XLEN-1:0]           i_addr,
   input  logic [XLEN-1:0]           i_wdata,
   input  logic [XLEN/8-1:0]         i_wstrb,
   input  logic                      i_trap_req,
   output logic                      o_stall,
   output logic                      o_done,
   output logic [XLEN-1:0]           o_rdata,
   output logic                      o_t_access_fault,
   output logic                      o_fault_store,
   output logic [N_REGIONS-1:0]      o_m_valid,
   output logic                      o_m_we,
   output logic [XLEN-1:0]           o_m_addr,
   output logic [XLEN-1:0]           o_m_wdata,
   output logic [XLEN/8-1:0]         o_m_wstrb,
   input  logic [N_REGIONS-1:0]      i_m_ready,
   input  logic [N_REGIONS*XLEN-1:0] i_m_rdata
);

   localparam int SEL_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP, FAULT} state_t;

   state_t             state, nxt;
   logic               we_q;
   logic [XLEN-1:0]    addr_q, wdata_q;
   logic [XLEN/8-1:0]  wstrb_q;
   logic [SEL_W-1:0]   sel_q, hit_sel;
   logic               hit, accept, sel_ready, timed_out;

   assign accept    = (state == IDLE) && i_req && !i_trap_req;
   assign sel_ready = i_m_ready[sel_q];

   // Descending scan so the lowest-index hitting region is the last to write.
   always_comb begin
      hit     = 1'b0;
      hit_sel = '0;
      for (int i = N_REGIONS - 1; i >= 0; i--) begin
         if ((i_addr & REGION_MASK[i]) == REGION_BASE[i]) begin
            hit     = 1'b1;
            hit_sel = SEL_W'(i);
         end
      end
   end

`ifdef COTM32_BUS_TIMEOUT_EN
   localparam int TC_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TC_W-1:0] tcnt;

   // Held at zero outside ACCESS, so it starts from zero on every entry.
   always_ff @(posedge i_clk) begin
      if (i_rst || state != ACCESS) tcnt <= '0;
      else                          tcnt <= tcnt + 1'b1;
   end

   assign timed_out = (tcnt == TC_W'(TIMEOUT_CYCLES - 1));
`else
   assign timed_out = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (accept) nxt = hit ? ACCESS : FAULT;
         ACCESS:  if (sel_ready)      nxt = RESP;
                  else if (timed_out) nxt = FAULT;
         RESP:    nxt = IDLE;
         FAULT:   nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         sel_q   <= '0;
      end else if (accept) begin
         we_q    <= i_we;
         addr_q  <= i_addr;
         wdata_q <= i_wdata;
         wstrb_q <= i_wstrb;
         sel_q   <= hit_sel;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)
         o_rdata <= '0;
      else if (state == ACCESS && sel_ready && !we_q)
         o_rdata <= i_m_rdata[sel_q*XLEN +: XLEN];
   end

   // Valid is gated by reset directly so a reset drops it in the same cycle.
   always_comb begin
      o_m_valid = '0;
      if (state == ACCESS && !i_rst) o_m_valid[sel_q] = 1'b1;
   end

   assign o_done           = (state == RESP);
   assign o_t_access_fault = (state == FAULT);
   assign o_fault_store    = (state == FAULT) && we_q;
   assign o_stall          = i_req && !o_done && !o_t_access_fault;
   assign o_m_we           = we_q;
   assign o_m_addr         = addr_q;
   assign o_m_wdata        = wdata_q;
   assign o_m_wstrb        = wstrb_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
module tb_lsu_bus_bridge;

   logic        clk = 1'b0;
   logic        rst, req, we, trap;
   logic [31:0] addr, wdata;
   logic [3:0]  wstrb;
   logic        stall, done, fault, fault_store, m_we;
   logic [31:0] rdata, m_addr, m_wdata;
   logic [3:0]  m_wstrb;
   logic [1:0]  m_valid, m_ready;
   logic [63:0] m_rdata;

   int errs   = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lsu_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr),
      .i_wdata(wdata), .i_wstrb(wstrb), .i_trap_req(trap),
      .o_stall(stall), .o_done(done), .o_rdata(rdata),
      .o_t_access_fault(fault), .o_fault_store(fault_store),
      .o_m_valid(m_valid), .o_m_we(m_we), .o_m_addr(m_addr),
      .o_m_wdata(m_wdata), .o_m_wstrb(m_wstrb),
      .i_m_ready(m_ready), .i_m_rdata(m_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; we = 1'b0; trap = 1'b0;
      addr = '0; wdata = '0; wstrb = '0; m_ready = '0; m_rdata = '0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_stall", stall, 0);
      chk("rst_done", done, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_fault", fault, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_maddr", m_addr, 0);

      // Load 0x10 from region0, ready in cycle 1
      req = 1'b1; we = 1'b0; addr = 32'h0000_0010;
      #1 chk("ld0_c0_stall", stall, 1);
      chk("ld0_c0_valid", m_valid, 0);
      tick();
      chk("ld0_c1_valid", m_valid, 2'b01);
      chk("ld0_c1_stall", stall, 1);
      chk("ld0_c1_maddr", m_addr, 32'h10);
      chk("ld0_c1_mwe", m_we, 0);
      m_ready = 2'b01; m_rdata[31:0] = 32'hDEAD_BEEF;
      tick();
      chk("ld0_c2_done", done, 1);
      chk("ld0_c2_rdata", rdata, 32'hDEAD_BEEF);
      chk("ld0_c2_stall", stall, 0);
      chk("ld0_c2_valid", m_valid, 0);
      req = 1'b0; m_ready = 2'b00;
      tick();
      chk("ld0_c3_done", done, 0);

      // Store to region1 with 3 waits; region0 ready meanwhile must be ignored
      req = 1'b1; we = 1'b1; addr = 32'h1000_0004; wdata = 32'h1234_5678; wstrb = 4'b0011;
      m_rdata = {32'hAAAA_AAAA, 32'hBBBB_BBBB};
      tick();
      addr = 32'h0; wdata = 32'h0; wstrb = 4'b0;
      for (int c = 1; c <= 4; c++) begin
         chk($sformatf("st_c%0d_valid", c), m_valid, 2'b10);
         chk($sformatf("st_c%0d_maddr", c), m_addr, 32'h1000_0004);
         chk($sformatf("st_c%0d_mwdata", c), m_wdata, 32'h1234_5678);
         chk($sformatf("st_c%0d_mwstrb", c), m_wstrb, 4'b0011);
         chk($sformatf("st_c%0d_mwe", c), m_we, 1);
         chk($sformatf("st_c%0d_done", c), done, 0);
         m_ready = (c == 4) ? 2'b10 : 2'b01;
         tick();
      end
      chk("st_c5_done", done, 1);
      chk("st_c5_rdata", rdata, 32'hDEAD_BEEF);
      chk("st_c5_valid", m_valid, 0);
      req = 1'b0; m_ready = 2'b00;
      tick();

      // Load from region1 with both slaves ready: region1 data must be taken
      req = 1'b1; we = 1'b0; addr = 32'h1000_0008;
      m_rdata = {32'hCAFE_F00D, 32'h0BAD_0BAD};
      tick();
      chk("ld1_c1_valid", m_valid, 2'b10);
      m_ready = 2'b11;
      tick();
      chk("ld1_c2_done", done, 1);
      chk("ld1_c2_rdata", rdata, 32'hCAFE_F00D);
      req = 1'b0; m_ready = 2'b00;
      tick();

      // Unmapped load then unmapped store
      req = 1'b1; we = 1'b0; addr = 32'h2000_0000;
      tick();
      chk("ufl_c1_fault", fault, 1);
      chk("ufl_c1_fstore", fault_store, 0);
      chk("ufl_c1_valid", m_valid, 0);
      chk("ufl_c1_stall", stall, 0);
      chk("ufl_c1_done", done, 0);
      req = 1'b0;
      tick();
      chk("ufl_c2_fault", fault, 0);
      chk("ufl_c2_valid", m_valid, 0);
      req = 1'b1; we = 1'b1; addr = 32'hF000_0000;
      tick();
      chk("ufs_c1_fault", fault, 1);
      chk("ufs_c1_fstore", fault_store, 1);
      chk("ufs_c1_valid", m_valid, 0);
      req = 1'b0;
      tick();
      chk("ufs_c2_fstore", fault_store, 0);

      // Trap blocks acceptance; dropping it lets the access start
      req = 1'b1; we = 1'b0; addr = 32'h0000_0040; trap = 1'b1;
      tick();
      chk("trap_c1_valid", m_valid, 0);
      chk("trap_c1_fault", fault, 0);
      chk("trap_c1_stall", stall, 1);
      trap = 1'b0;
      tick();
      chk("trap_c2_valid", m_valid, 2'b01);
      trap = 1'b1;
      m_rdata = {32'h0, 32'h1111_2222};
      tick();
      chk("trap_c3_valid_mid", m_valid, 2'b01);
      m_ready = 2'b01;
      tick();
      chk("trap_c4_done", done, 1);
      chk("trap_c4_rdata", rdata, 32'h1111_2222);
      req = 1'b0; trap = 1'b0; m_ready = 2'b00;
      tick();

      // Slave never ready
      req = 1'b1; we = 1'b0; addr = 32'h0000_0020;
      tick();
`ifdef COTM32_BUS_TIMEOUT_EN
      for (int c = 1; c <= 4; c++) begin
         chk($sformatf("to_c%0d_valid", c), m_valid, 2'b01);
         chk($sformatf("to_c%0d_fault", c), fault, 0);
         tick();
      end
      chk("to_c5_fault", fault, 1);
      chk("to_c5_fstore", fault_store, 0);
      chk("to_c5_valid", m_valid, 0);
      chk("to_c5_done", done, 0);
      req = 1'b0;
      tick();
`else
      for (int c = 1; c <= 20; c++) begin
         chk($sformatf("wait_c%0d_valid", c), m_valid, 2'b01);
         chk($sformatf("wait_c%0d_stall", c), stall, 1);
         chk($sformatf("wait_c%0d_fault", c), fault, 0);
         tick();
      end
      m_rdata = {32'h0, 32'h5555_AAAA};
      m_ready = 2'b01;
      tick();
      chk("wait_done", done, 1);
      chk("wait_rdata", rdata, 32'h5555_AAAA);
      req = 1'b0; m_ready = 2'b00;
      tick();
`endif

      // Reset mid-ACCESS
      req = 1'b1; we = 1'b0; addr = 32'h0000_0030;
      tick();
      chk("rst_mid_c1_valid", m_valid, 2'b01);
      rst = 1'b1;
      #1 chk("rst_mid_valid_now", m_valid, 0);
      tick();
      rst = 1'b0; req = 1'b0;
      #1 chk("rst_mid_valid", m_valid, 0);
      chk("rst_mid_done", done, 0);
      chk("rst_mid_rdata", rdata, 0);
      chk("rst_mid_fault", fault, 0);
      tick();
      chk("rst_mid_idle_valid", m_valid, 0);

      // Recovery after reset
      req = 1'b1; addr = 32'h0000_0044;
      m_rdata = {32'h0, 32'h7777_8888};
      tick();
      chk("rec_c1_valid", m_valid, 2'b01);
      m_ready = 2'b01;
      tick();
      chk("rec_c2_done", done, 1);
      chk("rec_c2_rdata", rdata, 32'h7777_8888);
      req = 1'b0; m_ready = 2'b00;
      tick();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
